// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern serializer.
package pattern_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Matches the target sequence of the companion Moore detector.
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
endpackage

// File: rtl/pattern_shift_reg.sv
// WIDTH-bit MSB-first shift register with parallel load; zero-fills from the LSB.
module pattern_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             msb_o
);
  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sr_q <= '0;
    else if (load_i)  sr_q <= din_i;
    else if (shift_i) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
  end

  assign msb_o = sr_q[WIDTH-1];
endmodule

// File: rtl/pattern_serializer.sv
// Sends a latched pattern MSB-first, repeat_n times, with optional idle gaps between copies.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap,
  output logic             x_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);
  localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);
  localparam logic [BC_W-1:0] BIT_PENULT = BC_W'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] gap_reg_q, gap_reg_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             sr_load, sr_shift;
  logic [WIDTH-1:0] sr_din;

  // The shift register's MSB is x_out; shifting out the final bit leaves it all-zero,
  // so x_out is naturally 0 in GAP, DONE and IDLE.
  pattern_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .din_i   (sr_din),
    .msb_o   (x_out)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_reg_d = gap_reg_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = (state_q == IDLE) ? pattern : pat_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          pat_d     = pattern;
          rep_cnt_d = repeat_n;
          gap_reg_d = gap;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          if (repeat_n != '0) begin
            state_d = SHIFT;
            sr_load = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bit_cnt_q != BIT_LAST) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          valid_d   = 1'b1;
          last_d    = (bit_cnt_q == BIT_PENULT);
        end else begin
          rep_cnt_d = rep_cnt_q - 1'b1;
          bit_cnt_d = '0;
          if (rep_cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            sr_shift = 1'b1;
            done_d   = 1'b1;
          end else if (gap_reg_q == '0) begin
            sr_load = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d   = GAP;
            sr_shift  = 1'b1;
            gap_cnt_d = gap_reg_q;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == CNT_W'(1)) begin
          state_d   = SHIFT;
          sr_load   = 1'b1;
          valid_d   = 1'b1;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_reg_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_reg_q <= gap_reg_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bit_valid = valid_q;
  assign last_bit  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule
